// File: rtl/bnn_mvu_pkg.sv
// Shared types and width helpers for the folded binary matrix-vector unit.
package bnn_mvu_pkg;

    typedef enum logic {
        ACC,
        HOLD
    } state_t;

    function automatic int acc_width(input int simd, input int fold);
        return $clog2(simd * fold + 1);
    endfunction

    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/bnn_popcount.sv
// Combinational popcount built as a balanced binary adder tree.
module bnn_popcount
    import bnn_mvu_pkg::*;
#(
    parameter int N = 8
) (
    input  logic [N-1:0]            bits,
    output logic [$clog2(N+1)-1:0]  count
);

    localparam int W = $clog2(N + 1);

    if (N == 1) begin : g_leaf
        assign count = bits;
    end else begin : g_split
        localparam int L = N / 2;
        localparam int H = N - L;

        logic [$clog2(L+1)-1:0] cnt_lo;
        logic [$clog2(H+1)-1:0] cnt_hi;

        bnn_popcount #(.N(L)) u_lo (
            .bits  (bits[L-1:0]),
            .count (cnt_lo)
        );

        bnn_popcount #(.N(H)) u_hi (
            .bits  (bits[N-1:L]),
            .count (cnt_hi)
        );

        assign count = W'(cnt_lo) + W'(cnt_hi);
    end

endmodule

// File: rtl/bnn_xnor_popcount_mvu.sv
// Folded XNOR-popcount matrix-vector unit with runtime weight store.
// Define BNN_MVU_THRESH_EN to emit one thresholded bit per channel.
module bnn_xnor_popcount_mvu
    import bnn_mvu_pkg::*;
#(
    parameter int SIMD   = 288,
    parameter int PE     = 64,
    parameter int FOLD   = 1,
    parameter int ACC_W  = acc_width(SIMD, FOLD),
    parameter int THRESH = SIMD * FOLD / 2
) (
    input  logic                          ap_clk,
    input  logic                          ap_rst,
    input  logic [SIMD-1:0]               in_data,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic                          wr_en,
    input  logic [clog2_min1(PE)-1:0]     wr_pe,
    input  logic [clog2_min1(FOLD)-1:0]   wr_fold,
    input  logic [SIMD-1:0]               wr_data,
`ifdef BNN_MVU_THRESH_EN
    output logic [PE-1:0]                 out_data,
`else
    output logic [PE*ACC_W-1:0]           out_data,
`endif
    output logic                          out_valid,
    input  logic                          out_ready
);

    localparam int FOLD_W = clog2_min1(FOLD);
    localparam int CNT_W  = $clog2(SIMD + 1);

    if (FOLD < 1 || THRESH < 0 || THRESH > SIMD * FOLD) begin : g_bad_cfg
        $error("bnn_xnor_popcount_mvu: bad FOLD or THRESH");
    end

    logic [SIMD-1:0]           w_mem [PE][FOLD];
    logic [FOLD_W-1:0]         fold_cnt;
    logic [ACC_W-1:0]          acc      [PE];
    logic [ACC_W-1:0]          acc_next [PE];
    logic [CNT_W-1:0]          pc       [PE];
    logic [$bits(out_data)-1:0] out_next;
    logic                      last_beat;
    logic                      fire;
    state_t                    state;

    assign last_beat = (fold_cnt == FOLD_W'(FOLD - 1));
    assign in_ready  = !(out_valid && !out_ready && last_beat);
    assign fire      = in_valid && in_ready;

    // Weight RAM: no reset, read-before-write on a same-cycle collision.
    always_ff @(posedge ap_clk) begin
        if (wr_en) begin
            w_mem[wr_pe][wr_fold] <= wr_data;
        end
    end

    for (genvar p = 0; p < PE; p++) begin : g_pe
        logic [SIMD-1:0] match;

        assign match = ~(w_mem[p][fold_cnt] ^ in_data);

        bnn_popcount #(.N(SIMD)) u_pc (
            .bits  (match),
            .count (pc[p])
        );
    end

    always_comb begin
        for (int p = 0; p < PE; p++) begin
            acc_next[p] = (fold_cnt == '0) ? ACC_W'(pc[p])
                                           : acc[p] + ACC_W'(pc[p]);
        end
    end

    always_comb begin
        out_next = '0;
        for (int p = 0; p < PE; p++) begin
`ifdef BNN_MVU_THRESH_EN
            out_next[p] = (acc_next[p] >= ACC_W'(THRESH));
`else
            out_next[p*ACC_W +: ACC_W] = acc_next[p];
`endif
        end
    end

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            fold_cnt  <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            state     <= ACC;
            for (int p = 0; p < PE; p++) begin
                acc[p] <= '0;
            end
        end else begin
            if (fire) begin
                fold_cnt <= last_beat ? '0 : fold_cnt + FOLD_W'(1);
                for (int p = 0; p < PE; p++) begin
                    acc[p] <= acc_next[p];
                end
            end

            // A final beat may reload the register in the cycle it drains.
            if (fire && last_beat) begin
                out_data  <= out_next;
                out_valid <= 1'b1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end

            unique case (state)
                ACC: begin
                    if (last_beat && out_valid && !out_ready) begin
                        state <= HOLD;
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        state <= ACC;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bnn_xnor_popcount_mvu.sv
// Scoreboard bench for bnn_xnor_popcount_mvu (SIMD=8, PE=4, FOLD=2).
module tb_bnn_xnor_popcount_mvu;

    localparam int SIMD   = 8;
    localparam int PE     = 4;
    localparam int FOLD   = 2;
    localparam int THRESH = 9;
    localparam int ACC_W  = 5;
`ifdef BNN_MVU_THRESH_EN
    localparam int OUT_W  = PE;
`else
    localparam int OUT_W  = PE * ACC_W;
`endif

    logic             ap_clk;
    logic             ap_rst;
    logic [SIMD-1:0]  in_data;
    logic             in_valid;
    logic             in_ready;
    logic             wr_en;
    logic [1:0]       wr_pe;
    logic [0:0]       wr_fold;
    logic [SIMD-1:0]  wr_data;
    logic [OUT_W-1:0] out_data;
    logic             out_valid;
    logic             out_ready;

    bnn_xnor_popcount_mvu #(
        .SIMD   (SIMD),
        .PE     (PE),
        .FOLD   (FOLD),
        .THRESH (THRESH)
    ) dut (
        .ap_clk    (ap_clk),
        .ap_rst    (ap_rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .wr_en     (wr_en),
        .wr_pe     (wr_pe),
        .wr_fold   (wr_fold),
        .wr_data   (wr_data),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    initial ap_clk = 1'b0;
    always #5 ap_clk = ~ap_clk;

    logic [SIMD-1:0]  mw [PE][FOLD];
    int               macc [PE];
    int               fcnt;
    logic [OUT_W-1:0] q [$];
    int               checks;
    int               errors;

    function automatic logic [OUT_W-1:0] pack4(input int c0, input int c1,
                                               input int c2, input int c3);
        logic [OUT_W-1:0] r;
        int c [PE];
        c = '{c0, c1, c2, c3};
        r = '0;
        for (int p = 0; p < PE; p++) begin
`ifdef BNN_MVU_THRESH_EN
            r[p] = (c[p] >= THRESH);
`else
            r[p*ACC_W +: ACC_W] = ACC_W'(c[p]);
`endif
        end
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: compare against the model, advance the model, clock the DUT.
    task automatic tick();
        logic exp_v;
        logic exp_r;
        int   pc;
        #1;
        exp_v = (q.size() != 0);
        exp_r = !(exp_v && !out_ready && fcnt == FOLD - 1);
        check("out_valid", 32'(out_valid), 32'(exp_v));
        check("in_ready", 32'(in_ready), 32'(exp_r));
        if (exp_v) check("out_data", 32'(out_data), 32'(q[0]));
        if (exp_v && out_ready) void'(q.pop_front());
        if (in_valid && exp_r) begin
            for (int p = 0; p < PE; p++) begin
                pc = $countones(~(mw[p][fcnt] ^ in_data));
                macc[p] = (fcnt == 0) ? pc : macc[p] + pc;
            end
            if (fcnt == FOLD - 1) begin
                q.push_back(pack4(macc[0], macc[1], macc[2], macc[3]));
                fcnt = 0;
            end else begin
                fcnt++;
            end
        end
        if (wr_en) mw[wr_pe][wr_fold] = wr_data;
        @(posedge ap_clk);
        @(negedge ap_clk);
    endtask

    task automatic wr(input int pe, input int fold, input logic [7:0] d);
        wr_en   = 1'b1;
        wr_pe   = 2'(pe);
        wr_fold = 1'(fold);
        wr_data = d;
        tick();
        wr_en   = 1'b0;
    endtask

    task automatic fill(input logic [7:0] d);
        for (int p = 0; p < PE; p++)
            for (int f = 0; f < FOLD; f++)
                wr(p, f, d);
    endtask

    task automatic beat(input logic [7:0] d);
        in_valid = 1'b1;
        in_data  = d;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic check_out(input string tag, input logic [OUT_W-1:0] exp);
        check({tag, "_valid"}, 32'(out_valid), 32'd1);
        check({tag, "_data"}, 32'(out_data), 32'(exp));
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        fcnt      = 0;
        ap_rst    = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        wr_en     = 1'b0;
        wr_pe     = '0;
        wr_fold   = '0;
        wr_data   = '0;
        out_ready = 1'b0;
        @(negedge ap_clk);
        @(negedge ap_clk);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        ap_rst    = 1'b0;
        out_ready = 1'b1;

        // All-ones weights and data
        fill(8'hFF);
        beat(8'hFF);
        check("lat_not_yet", 32'(out_valid), 32'd0);
        beat(8'hFF);
        check_out("ones", pack4(16, 16, 16, 16));
        tick();

        // Zero weights, then channel 2 rewritten
        fill(8'h00);
        beat(8'hAA);
        beat(8'h55);
        check_out("alt", pack4(8, 8, 8, 8));
        wr(2, 0, 8'hF0);
        wr(2, 1, 8'hF0);
        beat(8'hF0);
        beat(8'h0F);
        check_out("ch2", pack4(8, 8, 8, 8));
        tick();

        // Backpressure: second final beat stalls, first result held
        out_ready = 1'b0;
        beat(8'h00);
        beat(8'h00);
        check_out("bp_first", pack4(16, 16, 8, 16));
        beat(8'hFF);
        in_valid = 1'b1;
        in_data  = 8'h00;
        #1;
        check("bp_stall", 32'(in_ready), 32'd0);
        tick();
        tick();
        check_out("bp_hold", pack4(16, 16, 8, 16));
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        check_out("bp_second", pack4(8, 8, 8, 8));
        tick();

        // Reset mid-vector with a held result
        fill(8'hFF);
        out_ready = 1'b0;
        beat(8'hFF);
        beat(8'hFF);
        check_out("pre_rst", pack4(16, 16, 16, 16));
        beat(8'hAA);
        ap_rst = 1'b1;
        #1;
        check("rst_async_valid", 32'(out_valid), 32'd0);
        check("rst_async_data", 32'(out_data), 32'd0);
        check("rst_async_ready", 32'(in_ready), 32'd1);
        q.delete();
        fcnt = 0;
        tick();
        ap_rst    = 1'b0;
        out_ready = 1'b1;
        beat(8'hFF);
        beat(8'h00);
        check_out("post_rst", pack4(8, 8, 8, 8));
        tick();

        // Weight write colliding with a fold-0 beat
        wr_en    = 1'b1;
        wr_pe    = 2'd1;
        wr_fold  = 1'b0;
        wr_data  = 8'h00;
        in_valid = 1'b1;
        in_data  = 8'hFF;
        tick();
        wr_en = 1'b0;
        beat(8'hFF);
        check_out("wr_old", pack4(16, 16, 16, 16));
        beat(8'hFF);
        beat(8'hFF);
        check_out("wr_new", pack4(16, 8, 16, 16));
        tick();

        // Threshold boundary: 9 and 8
        wr(1, 0, 8'hFF);
        beat(8'hFF);
        beat(8'h01);
        check_out("thr9", pack4(9, 9, 9, 9));
        beat(8'hFF);
        beat(8'h00);
        check_out("thr8", pack4(8, 8, 8, 8));
        tick();

        // Random traffic with stalls and weight writes
        for (int i = 0; i < 80; i++) begin
            in_valid  = 1'($urandom_range(0, 1));
            in_data   = 8'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            wr_en     = ($urandom_range(0, 7) == 0);
            wr_pe     = 2'($urandom);
            wr_fold   = 1'($urandom);
            wr_data   = 8'($urandom);
            tick();
        end
        in_valid  = 1'b0;
        wr_en     = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/bnn_xnor_popcount_mvu.md
# bnn_xnor_popcount_mvu

Folded binary matrix-vector unit for the BNN datapath. It streams SIMD-bit activation words and XNORs each against a runtime-loadable weight row for each of PE output channels. It accumulates popcounts over FOLD beats and emits one packed vector of per-channel counts per input vector. It supersedes fixed-constant combinational XNOR arrays: weights, width, channel count and fold depth are parameters, and results are accumulated and handshaked.

## Interface
- SIMD, 288, activation bits per input beat
- PE, 64, output channels (weight rows)
- FOLD, 1, input beats per vector; must be ≥1
- ACC_W, $clog2(SIMD*FOLD+1), per-channel count width
- THRESH, SIMD*FOLD/2, compare value; used only with the threshold feature
- ap_clk  in  1  clock; all logic on the rising edge
- ap_rst  in  1  reset; asynchronous, active-high
- in_data  in  SIMD  activation word
- in_valid  in  1  in_data valid
- in_ready  out  1  beat accepted when in_valid & in_ready
- wr_en  in  1  weight write strobe
- wr_pe  in  $clog2(PE) (min 1)  target channel
- wr_fold  in  $clog2(FOLD) (min 1)  target fold slot
- wr_data  in  SIMD  weight word
- out_data  out  PE*ACC_W  channel p occupies bits [p*ACC_W +: ACC_W] (threshold build: PE bits)
- out_valid  out  1  result valid
- out_ready  in  1  result consumed when out_valid & out_ready

## Operation
- Weight store: PE×FOLD words of SIMD bits, not reset. Contents are undefined until written. A write lands at the clock edge. A read of the same address in the same cycle returns the old word.
- Per accepted beat, for each channel p: pc = popcount(~(W[p][fold_cnt] ^ in_data)).
  - If fold_cnt==0: acc[p] = pc.
  - Otherwise: acc[p] += pc.
  - Sums are unsigned and cannot overflow ACC_W.
- fold_cnt counts 0..FOLD-1 and wraps to 0 after the last beat. With FOLD=1 every beat is a final beat.
- On an accepted final beat, the final sums are loaded into the output register and out_valid sets.
- Control states:
  - ACC: accumulating.
  - HOLD: output register full and a final beat is pending.
  - ACC→HOLD when fold_cnt==FOLD-1 and out_valid & !out_ready.
  - HOLD→ACC when out_ready.
- in_ready = !(out_valid & !out_ready & fold_cnt==FOLD-1). Non-final beats are never stalled by output backpressure.
- Final beat accepted in the same cycle that out_ready drains the register: the new result loads and out_valid stays 1.
- out_data is stable while out_valid & !out_ready.

## Timing
- Reset values:
  - out_valid=0, out_data=0, in_ready=1.
  - fold_cnt=0, acc=0, state ACC.
  - Weights are unaffected.
- Reset mid-vector discards the partial accumulation. The next accepted beat is treated as fold 0.
- Latency: out_valid rises one cycle after the final beat is accepted.
- Throughput: one beat per cycle; one result per FOLD cycles when out_ready=1.
- No combinational path from in_valid to out_valid. in_ready depends combinationally on out_ready.

## Configuration
- BNN_MVU_THRESH_EN defined:
  - Output per channel is 1 bit: acc[p] >= THRESH.
  - out_data width is PE.
  - Counts are not exported.
- BNN_MVU_THRESH_EN undefined: out_data carries the full ACC_W counts.
- All other behaviour is identical in both builds.

## Structure
- Shared package bnn_mvu_pkg holds:
  - the ACC_W derivation function
  - the clog2-with-minimum-1 helper for address widths
  - the state enum (ACC, HOLD)
- Sub-module bnn_popcount: parametrised SIMD-bit adder tree, instantiated PE times. It is combinational and has no clock or reset.

## Test plan
Bench configuration: SIMD=8, PE=4, FOLD=2, THRESH=9.
- All weights 0xFF; beats 0xFF, 0xFF → out_data counts 16,16,16,16; out_valid one cycle after the 2nd beat.
- All weights 0x00; beats 0xAA, 0x55 → counts 8 each. Channel 2 rewritten to 0xF0 in both slots, then beats 0xF0, 0x0F → channel 2 = 8 + 0 = 8, channels 0,1,3 = 4 + 4 = 8.
- out_ready=0, two vectors streamed back to back → in_ready low only on the second vector's final beat; first result held unchanged. Raise out_ready → second result appears next cycle.
- ap_rst pulsed after the first beat of a vector → out_valid=0 immediately. The next two beats (weights 0xFF, data 0xFF, 0x00) → counts 8.
- Weight write to (pe 1, fold 0) in the same cycle as a fold-0 beat → that beat uses the old weight; the following vector uses the new one.
- BNN_MVU_THRESH_EN build, weights 0xFF, beats 0xFF and 0x01 → count 9 → bits 1111. Beats 0xFF and 0x00 → count 8 → bits 0000.
